dpic_ram_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-cycle DPI-C simulation RAM port between NUM_REQ requesters, e.g. instruction fetch, load/store unit and debug/DMA.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- One transaction is issued to the RAM per cycle, and only while the response slot is free.
- The read data is registered and returned to the granted requester on the following cycle.

---
 rtl/dpic_bus_pkg.sv | 21 ++
 rtl/dpic_ram_arbiter_if.sv | 41 ++++
 rtl/dpic_ram_arbiter_rr_pick.sv | 36 +++
 rtl/dpic_ram_arbiter.sv | 129 ++++++++++++
 tb/tb_dpic_ram_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpic_bus_pkg.sv
// Shared definitions for the DPI-C RAM bus: access sizes, arbiter states, index width.
// Pure declarations, no logic and no latency.
// No flow control lives here.
package dpic_bus_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,  // response slot empty
    ST_RESP = 1'b1   // response slot holds data for the owner
  } arb_state_e;

  // Width of a requester index; a single requester still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dpic_ram_arbiter_if.sv
// Requester and RAM-port signals of the DPI-C RAM arbiter, per-requester fields flattened.
// Wires only, no latency.
// valid/ready on both request and response channels; the RAM port has no backpressure.
interface dpic_ram_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr;
  logic [NUM_REQ-1:0]                  req_we;
  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wmask;
  logic [NUM_REQ*2-1:0]                req_size;
  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata;
  logic [NUM_REQ-1:0]                  resp_valid;
  logic [NUM_REQ-1:0]                  resp_ready;
  logic [DATA_WIDTH-1:0]               resp_rdata;
  logic                                ram_en;
  logic                                ram_re;
  logic                                ram_we;
  logic [ADDR_WIDTH-1:0]               ram_addr;
  logic [DATA_WIDTH/8-1:0]             ram_wmask;
  logic [1:0]                          ram_size;
  logic [DATA_WIDTH-1:0]               ram_wdata;
  logic [DATA_WIDTH-1:0]               ram_rdata;

  // Arbiter side
  modport slave (
    input  req_valid, req_addr, req_we, req_wmask, req_size, req_wdata, resp_ready, ram_rdata,
    output req_ready, resp_valid, resp_rdata,
           ram_en, ram_re, ram_we, ram_addr, ram_wmask, ram_size, ram_wdata
  );

  // Requester/RAM-model side
  modport master (
    output req_valid, req_addr, req_we, req_wmask, req_size, req_wdata, resp_ready, ram_rdata,
    input  req_ready, resp_valid, resp_rdata,
           ram_en, ram_re, ram_we, ram_addr, ram_wmask, ram_size, ram_wdata
  );
endinterface

// File: rtl/dpic_ram_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit of valid_i scanning upward from ptr_i, wrapping.
// Purely combinational, zero latency.
// No flow control; any_o low means grant_o is 0 and meaningless.
module rr_pick
  import dpic_bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk the N candidate positions starting at ptr_i and keep the first valid one
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!any_o && valid_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpic_ram_arbiter.sv
// Round-robin share of one single-cycle DPI-C RAM port among NUM_REQ requesters.
// Request issues combinationally to the RAM; response (registered rdata) appears 1 cycle later.
// A new request is accepted only while the response slot is empty or being consumed this cycle.
module dpic_ram_arbiter
  import dpic_bus_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  dpic_ram_arbiter_if.slave bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int MW = DATA_WIDTH / 8;

  generate
    if (ADDR_WIDTH > 32 || MW > 8 || NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_cfg
      $error("dpic_ram_arbiter: unsupported NUM_REQ/ADDR_WIDTH/DATA_WIDTH");
    end
  endgenerate

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         own_q, own_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IW-1:0]         grant;
  logic                  any_vld;
  logic                  can_issue;
  logic                  issue;

  logic [NUM_REQ-1:0]    req_ready_w;
  logic [NUM_REQ-1:0]    resp_valid_w;
  logic [DATA_WIDTH-1:0] resp_rdata_w;
  logic                  ram_en_w, ram_re_w, ram_we_w;
  logic [ADDR_WIDTH-1:0] ram_addr_w;
  logic [MW-1:0]         ram_wmask_w;
  logic [1:0]            ram_size_w;
  logic [DATA_WIDTH-1:0] ram_wdata_w;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .any_o   (any_vld)
  );

  // Slot frees in the same cycle the owner consumes it, giving one transaction per cycle.
  // rst_n gates issue so the DPI-C RAM call can never fire while reset is held.
  assign can_issue = (state_q == ST_IDLE) || bus.resp_ready[own_q];
  assign issue     = rst_n && can_issue && any_vld;

  // Request accept and RAM port: the granted slice in an issue cycle, all zero otherwise
  always_comb begin
    req_ready_w = '0;
    ram_en_w    = 1'b0;
    ram_re_w    = 1'b0;
    ram_we_w    = 1'b0;
    ram_addr_w  = '0;
    ram_wmask_w = '0;
    ram_size_w  = '0;
    ram_wdata_w = '0;
    if (issue) begin
      req_ready_w[grant] = 1'b1;
      ram_en_w    = 1'b1;
      ram_we_w    = bus.req_we[grant];
      ram_re_w    = !bus.req_we[grant];
      ram_addr_w  = bus.req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wmask_w = bus.req_wmask[int'(grant)*MW +: MW];
      ram_size_w  = bus.req_size[int'(grant)*2 +: 2];
      ram_wdata_w = bus.req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Response channel: one-hot owner and captured data while the slot is full
  always_comb begin
    resp_valid_w = '0;
    resp_rdata_w = '0;
    if (state_q == ST_RESP) begin
      resp_valid_w[own_q] = 1'b1;
      resp_rdata_w        = rdata_q;
    end
  end

  // Next state: fill the slot on issue, otherwise drain it once the owner consumes
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    rr_ptr_d = rr_ptr_q;
    rdata_d  = rdata_q;
    if (issue) begin
      state_d  = ST_RESP;
      own_d    = grant;
      rdata_d  = ram_we_w ? '0 : bus.ram_rdata;
      rr_ptr_d = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end else if (state_q == ST_RESP && bus.resp_ready[own_q]) begin
      state_d = ST_IDLE;
    end
  end

  // State register; async reset drops any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      own_q    <= '0;
      rr_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      rr_ptr_q <= rr_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.req_ready  = req_ready_w;
  assign bus.resp_valid = resp_valid_w;
  assign bus.resp_rdata = resp_rdata_w;
  assign bus.ram_en     = ram_en_w;
  assign bus.ram_re     = ram_re_w;
  assign bus.ram_we     = ram_we_w;
  assign bus.ram_addr   = ram_addr_w;
  assign bus.ram_wmask  = ram_wmask_w;
  assign bus.ram_size   = ram_size_w;
  assign bus.ram_wdata  = ram_wdata_w;

endmodule

// File: tb/tb_dpic_ram_arbiter.sv
// Bench for dpic_ram_arbiter: a 2-requester and a 3-requester instance share one RAM model.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// Responses are scored against an expected queue filled when requests are driven.
module tb_dpic_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;

  dpic_ram_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();
  dpic_ram_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  dpic_ram_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));
  dpic_ram_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  // RAM model: 256 words, combinational read, byte-masked write on posedge (dut2 only writes)
  logic [31:0] mem [0:255];
  logic        mem_init_done = 1'b0;

  assign b2.ram_rdata = mem[b2.ram_addr[9:2]];
  assign b3.ram_rdata = mem[b3.ram_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int w = 0; w < 256; w++) mem[w] <= 32'h0;
      mem[8'h40] <= 32'hDEADBEEF;  // 0x100
      mem[8'hC0] <= 32'hCAFEF00D;  // 0x300
      mem_init_done <= 1'b1;
    end else if (b2.ram_en && b2.ram_we) begin
      for (int b = 0; b < 4; b++)
        if (b2.ram_wmask[b]) mem[b2.ram_addr[9:2]][8*b +: 8] <= b2.ram_wdata[8*b +: 8];
    end
  end

  // Scoreboard for the 2-requester instance: pop on every response handshake
  always @(negedge clk) begin
    if (rst_n && (b2.resp_valid & b2.resp_ready) != 2'b00) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL sb2_unexpected resp_valid=%b rdata=%h with empty queue", b2.resp_valid, b2.resp_rdata);
      end else begin
        e2 = q2.pop_front();
        if (b2.resp_valid !== (2'(1) << e2.idx) || b2.resp_rdata !== e2.data) begin
          fails++;
          $display("FAIL sb2_resp got valid=%b rdata=%h expected valid=%b rdata=%h",
                   b2.resp_valid, b2.resp_rdata, 2'(1) << e2.idx, e2.data);
        end
      end
    end
  end

  // Scoreboard for the 3-requester instance
  always @(negedge clk) begin
    if (rst_n && (b3.resp_valid & b3.resp_ready) != 3'b000) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL sb3_unexpected resp_valid=%b rdata=%h with empty queue", b3.resp_valid, b3.resp_rdata);
      end else begin
        e3 = q3.pop_front();
        if (b3.resp_valid !== (3'(1) << e3.idx) || b3.resp_rdata !== e3.data) begin
          fails++;
          $display("FAIL sb3_resp got valid=%b rdata=%h expected valid=%b rdata=%h",
                   b3.resp_valid, b3.resp_rdata, 3'(1) << e3.idx, e3.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive2(input int i, input logic v, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] wm);
    b2.req_valid[i]          = v;
    b2.req_we[i]             = we;
    b2.req_addr[i*32 +: 32]  = addr;
    b2.req_wdata[i*32 +: 32] = wd;
    b2.req_wmask[i*4 +: 4]   = wm;
    b2.req_size[i*2 +: 2]    = 2'd2;
  endtask

  task automatic drive3(input int i, input logic v, input logic [31:0] addr);
    b3.req_valid[i]          = v;
    b3.req_we[i]             = 1'b0;
    b3.req_addr[i*32 +: 32]  = addr;
    b3.req_wdata[i*32 +: 32] = 32'h0;
    b3.req_wmask[i*4 +: 4]   = 4'h0;
    b3.req_size[i*2 +: 2]    = 2'd2;
  endtask

  task automatic test_reset();
    drive2(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    drive2(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    b2.resp_ready = 2'b11;
    cyc();
    mid();
    tests++;
    if (b2.req_ready !== 2'b00 || b2.resp_valid !== 2'b00 || b2.resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs req_ready=%b resp_valid=%b rdata=%h expected all 0",
               b2.req_ready, b2.resp_valid, b2.resp_rdata);
    end
    tests++;
    if ({b2.ram_en, b2.ram_re, b2.ram_we} !== 3'b000 || b2.ram_addr !== 32'h0 ||
        b2.ram_wdata !== 32'h0 || b2.ram_wmask !== 4'h0 || b2.ram_size !== 2'd0) begin
      fails++;
      $display("FAIL reset_ram en/re/we=%b addr=%h expected 000/0",
               {b2.ram_en, b2.ram_re, b2.ram_we}, b2.ram_addr);
    end
    cyc();
    drive2(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive2(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_read();
    drive2(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    q2.push_back('{0, 32'hDEADBEEF});
    mid();
    tests++;
    if (b2.req_ready !== 2'b01 || b2.ram_en !== 1'b1 || b2.ram_re !== 1'b1 || b2.ram_we !== 1'b0) begin
      fails++;
      $display("FAIL read_issue req_ready=%b en=%b re=%b we=%b expected 01/1/1/0",
               b2.req_ready, b2.ram_en, b2.ram_re, b2.ram_we);
    end
    tests++;
    if (b2.ram_addr !== 32'h100 || b2.ram_size !== 2'd2) begin
      fails++;
      $display("FAIL read_addr addr=%h size=%0d expected 100/2", b2.ram_addr, b2.ram_size);
    end
    cyc();
    drive2(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mid();
    tests++;
    if (b2.resp_valid !== 2'b01 || b2.resp_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL read_resp valid=%b rdata=%h expected 01/deadbeef", b2.resp_valid, b2.resp_rdata);
    end
    cyc();
    mid();
    tests++;
    if (b2.resp_valid !== 2'b00 || b2.ram_en !== 1'b0) begin
      fails++;
      $display("FAIL read_idle valid=%b en=%b expected 00/0", b2.resp_valid, b2.ram_en);
    end
    cyc();
  endtask

  task automatic test_write_then_read();
    drive2(1, 1'b1, 1'b1, 32'h200, 32'h11223344, 4'b0011);
    q2.push_back('{1, 32'h0});
    mid();
    tests++;
    if (b2.req_ready !== 2'b10 || b2.ram_we !== 1'b1 || b2.ram_re !== 1'b0 ||
        b2.ram_wmask !== 4'b0011 || b2.ram_wdata !== 32'h11223344) begin
      fails++;
      $display("FAIL write_issue req_ready=%b we=%b re=%b wmask=%b wdata=%h expected 10/1/0/0011/11223344",
               b2.req_ready, b2.ram_we, b2.ram_re, b2.ram_wmask, b2.ram_wdata);
    end
    cyc();
    drive2(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    q2.push_back('{1, 32'h00003344});
    mid();
    tests++;
    if (b2.resp_valid !== 2'b10 || b2.resp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL write_ack valid=%b rdata=%h expected 10/0", b2.resp_valid, b2.resp_rdata);
    end
    tests++;
    if (b2.req_ready !== 2'b10 || b2.ram_re !== 1'b1) begin
      fails++;
      $display("FAIL read_after_write_issue req_ready=%b re=%b expected 10/1", b2.req_ready, b2.ram_re);
    end
    cyc();
    drive2(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mid();
    tests++;
    if (b2.resp_rdata !== 32'h00003344) begin
      fails++;
      $display("FAIL masked_read rdata=%h expected 00003344", b2.resp_rdata);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int          g;
    logic [31:0] a;
    drive2(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    drive2(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++)
      q2.push_back((k % 2 == 0) ? '{0, 32'hDEADBEEF} : '{1, 32'h00003344});
    for (int k = 0; k < 6; k++) begin
      g = k % 2;
      a = (g == 0) ? 32'h100 : 32'h200;
      mid();
      tests++;
      if (b2.req_ready !== (2'(1) << g) || b2.ram_en !== 1'b1 || b2.ram_addr !== a) begin
        fails++;
        $display("FAIL fair_grant_%0d req_ready=%b en=%b addr=%h expected %b/1/%h",
                 k, b2.req_ready, b2.ram_en, b2.ram_addr, 2'(1) << g, a);
      end
      cyc();
    end
    drive2(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive2(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cyc();
  endtask

  task automatic test_backpressure();
    drive2(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    q2.push_back('{0, 32'hDEADBEEF});
    cyc();
    drive2(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive2(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    q2.push_back('{1, 32'h00003344});
    b2.resp_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      mid();
      tests++;
      if (b2.resp_valid !== 2'b01 || b2.resp_rdata !== 32'hDEADBEEF ||
          b2.req_ready !== 2'b00 || b2.ram_en !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_%0d valid=%b rdata=%h req_ready=%b en=%b expected 01/deadbeef/00/0",
                 k, b2.resp_valid, b2.resp_rdata, b2.req_ready, b2.ram_en);
      end
      cyc();
    end
    b2.resp_ready = 2'b11;
    mid();
    tests++;
    if (b2.req_ready !== 2'b10 || b2.ram_en !== 1'b1 || b2.resp_valid !== 2'b01) begin
      fails++;
      $display("FAIL bp_release req_ready=%b en=%b valid=%b expected 10/1/01",
               b2.req_ready, b2.ram_en, b2.resp_valid);
    end
    cyc();
    drive2(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    mid();
    tests++;
    if (b2.resp_valid !== 2'b10 || b2.resp_rdata !== 32'h00003344) begin
      fails++;
      $display("FAIL bp_second_resp valid=%b rdata=%h expected 10/00003344", b2.resp_valid, b2.resp_rdata);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    b2.resp_ready = 2'b00;
    drive2(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    cyc();
    drive2(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    tests++;
    if (b2.resp_valid !== 2'b01) begin
      fails++;
      $display("FAIL arst_pending valid=%b expected 01", b2.resp_valid);
    end
    rst_n = 1'b0;
    drive2(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    drive2(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    #1;
    tests++;
    if (b2.resp_valid !== 2'b00 || b2.resp_rdata !== 32'h0 || b2.req_ready !== 2'b00 ||
        {b2.ram_en, b2.ram_re, b2.ram_we} !== 3'b000 || b2.ram_addr !== 32'h0) begin
      fails++;
      $display("FAIL arst_immediate valid=%b rdata=%h req_ready=%b en/re/we=%b addr=%h expected all 0",
               b2.resp_valid, b2.resp_rdata, b2.req_ready, {b2.ram_en, b2.ram_re, b2.ram_we}, b2.ram_addr);
    end
    mid();
    tests++;
    if (b2.req_ready !== 2'b00 || b2.ram_en !== 1'b0) begin
      fails++;
      $display("FAIL arst_no_accept req_ready=%b en=%b expected 00/0", b2.req_ready, b2.ram_en);
    end
    cyc();
    rst_n = 1'b1;
    b2.resp_ready = 2'b11;
    q2.push_back('{0, 32'hDEADBEEF});
    mid();
    tests++;
    if (b2.req_ready !== 2'b01 || b2.ram_en !== 1'b1) begin
      fails++;
      $display("FAIL arst_first_grant req_ready=%b en=%b expected 01/1", b2.req_ready, b2.ram_en);
    end
    cyc();
    drive2(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive2(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cyc();
  endtask

  task automatic test_rotation3();
    int          seq [7] = '{0, 1, 2, 0, 2, 0, 2};
    logic [31:0] dat [3] = '{32'hDEADBEEF, 32'h00003344, 32'hCAFEF00D};
    b3.resp_ready = 3'b111;
    drive3(0, 1'b1, 32'h100);
    drive3(1, 1'b1, 32'h200);
    drive3(2, 1'b1, 32'h300);
    for (int k = 0; k < 7; k++) q3.push_back('{seq[k], dat[seq[k]]});
    for (int k = 0; k < 7; k++) begin
      if (k == 4) drive3(1, 1'b0, 32'h200);
      mid();
      tests++;
      if (b3.req_ready !== (3'(1) << seq[k]) || b3.ram_en !== 1'b1) begin
        fails++;
        $display("FAIL rot3_grant_%0d req_ready=%b en=%b expected %b/1",
                 k, b3.req_ready, b3.ram_en, 3'(1) << seq[k]);
      end
      cyc();
    end
    drive3(0, 1'b0, 32'h0);
    drive3(2, 1'b0, 32'h0);
    cyc();
    cyc();
  endtask

  task automatic test_drain();
    tests++;
    if (q2.size() != 0 || q3.size() != 0) begin
      fails++;
      $display("FAIL drain q2=%0d q3=%0d responses outstanding expected 0/0", q2.size(), q3.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    b2.req_valid = '0; b2.req_we = '0; b2.req_addr = '0; b2.req_wmask = '0;
    b2.req_size = '0; b2.req_wdata = '0; b2.resp_ready = '0;
    b3.req_valid = '0; b3.req_we = '0; b3.req_addr = '0; b3.req_wmask = '0;
    b3.req_size = '0; b3.req_wdata = '0; b3.resp_ready = '0;

    test_reset();
    test_single_read();
    test_write_then_read();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_rotation3();
    test_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
